multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-style datapath controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait timeout to FAULT, sticky HALT/FAULT until reset.
//
// Ports:
//   clock      - rising-edge clock
//   start      - asynchronous active-low reset (low = reset state)
//   op         - opcode from the instruction register (OP_W bits)
//   eq         - ALU equality flag
//   mem_ready  - memory access completes this cycle
//   pc_wr, ir_wr, alu_src_a, reg_dst, mem_to_reg, reg_wr, mem_r, mem_w, pc_src
//              - datapath strobes and selects
//   alu_src_b  - 000 regB, 001 const 1, 010 sign-ext imm, 011 branch offset
//   alu_op     - 00 add, 01 subtract, 10 decode funct
//   halted     - high in HALT
//   fault      - high in FAULT
//   state      - current state code
module multicycle_ctrl #(
    parameter int OP_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic            eq,
    input  logic            mem_ready,
    output logic            pc_wr,
    output logic            ir_wr,
    output logic            alu_src_a,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_wr,
    output logic            mem_r,
    output logic            mem_w,
    output logic            pc_src,
    output logic [2:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            halted,
    output logic            fault,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_I   = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12,
        S_FAULT  = 4'd13
    } state_t;

    localparam logic [3:0] OPC_R    = 4'b0000;
    localparam logic [3:0] OPC_ADDI = 4'b0001;
    localparam logic [3:0] OPC_LW   = 4'b0010;
    localparam logic [3:0] OPC_SW   = 4'b0011;
    localparam logic [3:0] OPC_BEQ  = 4'b0100;
    localparam logic [3:0] OPC_BNE  = 4'b0101;
    localparam logic [3:0] OPC_JMP  = 4'b0110;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     cur;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       is_bne;
    logic       is_bne_nxt;

    logic [3:0] nib;
    logic       hi_zero;
    logic       in_wait;

    assign nib     = op[3:0];
    // Opcode bits above the low nibble must all be zero for a legal opcode.
    assign hi_zero = ((op >> 4) == '0);
    assign in_wait = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            cur      <= S_FETCH;
            wait_cnt <= 8'd0;
            is_bne   <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            is_bne   <= is_bne_nxt;
        end
    end

    // Counter runs only while a wait state is held; any transition clears it,
    // which also covers re-entry to FETCH/MEM_RD/MEM_WR.
    always_comb begin
        wait_nxt = 8'd0;
        if (in_wait && (nxt == cur)) begin
            wait_nxt = wait_cnt + 8'd1;
        end
    end

    // Branch flavour is latched in DECODE so op may change during BRANCH.
    always_comb begin
        is_bne_nxt = is_bne;
        if (cur == S_DECODE) begin
            is_bne_nxt = (nib == OPC_BNE);
        end
    end

    always_comb begin
        nxt        = cur;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        alu_src_a  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        pc_src     = 1'b0;
        alu_src_b  = 3'b000;
        alu_op     = 2'b00;

        unique case (cur)
            S_FETCH: begin
                mem_r     = 1'b1;
                alu_src_b = 3'b001;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
                if (mem_ready) begin
                    nxt = S_DECODE;
                end else if (wait_cnt == TO_LAST) begin
                    nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_b = 3'b011;
                nxt       = S_FAULT;
                if (hi_zero) begin
                    case (nib)
                        OPC_R:    nxt = S_EXEC_R;
                        OPC_ADDI: nxt = S_EXEC_I;
                        OPC_LW:   nxt = S_ADDR;
                        OPC_SW:   nxt = S_ADDR;
                        OPC_BEQ:  nxt = S_BRANCH;
                        OPC_BNE:  nxt = S_BRANCH;
                        OPC_JMP:  nxt = S_JUMP;
                        OPC_HALT: nxt = S_HALT;
                        default:  nxt = S_FAULT;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 3'b010;
                nxt       = S_WB_I;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 3'b010;
                nxt       = (nib == OPC_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_r = 1'b1;
                if (mem_ready) begin
                    nxt = S_WB_MEM;
                end else if (wait_cnt == TO_LAST) begin
                    nxt = S_FAULT;
                end
            end
            S_MEM_WR: begin
                mem_w = 1'b1;
                if (mem_ready) begin
                    nxt = S_FETCH;
                end else if (wait_cnt == TO_LAST) begin
                    nxt = S_FAULT;
                end
            end
            S_WB_R: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
                nxt     = S_FETCH;
            end
            S_WB_I: begin
                reg_wr = 1'b1;
                nxt    = S_FETCH;
            end
            S_WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_wr     = is_bne ? ~eq : eq;
                nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_src = 1'b1;
                nxt    = S_FETCH;
            end
            S_HALT:  nxt = S_HALT;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_FAULT;
        endcase
    end

    assign halted = (cur == S_HALT);
    assign fault  = (cur == S_FAULT);
    assign state  = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a generator plans per-cycle inputs and
// expected outputs per instruction; a driver issues them and a monitor checks.
module tb_multicycle_ctrl;

    localparam int OP_W = 5;
    localparam int TO   = 15;

    localparam logic [13:0] PCW     = 14'h2000;
    localparam logic [13:0] IRW     = 14'h1000;
    localparam logic [13:0] ASA     = 14'h0800;
    localparam logic [13:0] RDST    = 14'h0400;
    localparam logic [13:0] M2R     = 14'h0200;
    localparam logic [13:0] RW      = 14'h0100;
    localparam logic [13:0] MR      = 14'h0080;
    localparam logic [13:0] MW      = 14'h0040;
    localparam logic [13:0] PSRC    = 14'h0020;
    localparam logic [13:0] ASB_1   = 14'h0004;
    localparam logic [13:0] ASB_IMM = 14'h0008;
    localparam logic [13:0] ASB_BR  = 14'h000C;
    localparam logic [13:0] AOP_SUB = 14'h0001;
    localparam logic [13:0] AOP_F   = 14'h0002;

    typedef struct {
        logic [4:0]  op;
        logic        eq;
        logic        mr;
        logic        rst;
        logic [19:0] exp;
    } cyc_t;

    cyc_t        plan[$];
    logic [19:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ncyc   = 0;

    logic            clock = 1'b0;
    logic            start;
    logic [OP_W-1:0] op;
    logic            eq;
    logic            mem_ready;
    logic            pc_wr, ir_wr, alu_src_a, reg_dst, mem_to_reg;
    logic            reg_wr, mem_r, mem_w, pc_src, halted, fault;
    logic [2:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [3:0]      state;

    multicycle_ctrl #(.OP_W(OP_W), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .start(start), .op(op), .eq(eq),
        .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr),
        .alu_src_a(alu_src_a), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .mem_r(mem_r),
        .mem_w(mem_w), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .halted(halted), .fault(fault),
        .state(state)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] ev(input int st, input logic [13:0] f);
        logic [3:0] s;
        logic       h;
        logic       fl;
        s  = 4'(st);
        h  = (st == 12);
        fl = (st == 13);
        return {f, h, fl, s};
    endfunction

    task automatic put(input logic [4:0] o, input logic e, input logic mr,
                       input logic rst, input logic [19:0] x);
        cyc_t c;
        c.op  = o;
        c.eq  = e;
        c.mr  = mr;
        c.rst = rst;
        c.exp = x;
        plan.push_back(c);
    endtask

    // Cycle where op/eq/mem_ready are irrelevant to the outcome.
    task automatic idle(input int st, input logic [13:0] f);
        put(5'($urandom), 1'($urandom), 1'($urandom), 1'b0, ev(st, f));
    endtask

    task automatic rst_rec();
        logic mr;
        mr = 1'($urandom);
        put(5'($urandom), 1'($urandom), mr, 1'b1,
            ev(0, MR | ASB_1 | (mr ? (PCW | IRW) : 14'h0)));
    endtask

    task automatic stuck(input int st);
        int n;
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) idle(st, 14'h0);
        rst_rec();
    endtask

    // mode: -1 random, otherwise number of low-ready cycles before the
    // ready cycle; >= TO means the access times out.
    // res: 0 completed, 1 timed out (now in FAULT), 2 aborted by reset.
    task automatic mem_phase(input int st, input logic [13:0] fw,
                             input logic [13:0] fd, input int mode,
                             output int res);
        int w;
        int r;
        w = mode;
        if (mode < 0) begin
            r = $urandom_range(0, 19);
            if (r < 15) w = r % 4;
            else if (r < 17) w = TO - 1;
            else if (r == 17) w = TO;
            else if (r == 18 && st != 0) w = -2;
            else w = 0;
        end
        if (w == -2) begin
            r = $urandom_range(1, 3);
            for (int i = 0; i < r; i++)
                put(5'($urandom), 1'($urandom), 1'b0, 1'b0, ev(st, fw));
            rst_rec();
            res = 2;
        end else if (w >= TO) begin
            for (int i = 0; i < TO; i++)
                put(5'($urandom), 1'($urandom), 1'b0, 1'b0, ev(st, fw));
            res = 1;
        end else begin
            for (int i = 0; i < w; i++)
                put(5'($urandom), 1'($urandom), 1'b0, 1'b0, ev(st, fw));
            put(5'($urandom), 1'($urandom), 1'b1, 1'b0, ev(st, fd));
            res = 0;
        end
    endtask

    // kind: 0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 JMP, 7 HALT,
    // 8 random illegal nibble, 9 LW with op[4]=1, 10 opcode 1010
    task automatic instr(input int kind, input int fmode, input int dmode,
                         input int eqv);
        logic [4:0] o;
        logic       e;
        logic       take;
        int         res;
        mem_phase(0, MR | ASB_1, MR | ASB_1 | PCW | IRW, fmode, res);
        if (res == 1) begin
            stuck(13);
            return;
        end
        case (kind)
            0: o = 5'b00000;
            1: o = 5'b00001;
            2: o = 5'b00010;
            3: o = 5'b00011;
            4: o = 5'b00100;
            5: o = 5'b00101;
            6: o = 5'b00110;
            7: o = 5'b01111;
            8: o = {1'b0, 4'($urandom_range(7, 14))};
            9: o = 5'b10010;
            default: o = 5'b01010;
        endcase
        put(o, 1'($urandom), 1'($urandom), 1'b0, ev(1, ASB_BR));
        case (kind)
            0: begin
                idle(2, ASA | AOP_F);
                idle(7, RW | RDST);
            end
            1: begin
                idle(3, ASA | ASB_IMM);
                idle(8, RW);
            end
            2: begin
                put(o, 1'($urandom), 1'($urandom), 1'b0, ev(4, ASA | ASB_IMM));
                mem_phase(5, MR, MR, dmode, res);
                if (res == 0) idle(9, RW | M2R);
                else if (res == 1) stuck(13);
            end
            3: begin
                put(o, 1'($urandom), 1'($urandom), 1'b0, ev(4, ASA | ASB_IMM));
                mem_phase(6, MW, MW, dmode, res);
                if (res == 1) stuck(13);
            end
            4, 5: begin
                e    = (eqv < 0) ? 1'($urandom) : 1'(eqv);
                take = (kind == 5) ? !e : e;
                put(5'($urandom), e, 1'($urandom), 1'b0,
                    ev(10, ASA | AOP_SUB | PSRC | (take ? PCW : 14'h0)));
            end
            6: idle(11, PCW | PSRC);
            7: stuck(12);
            default: stuck(13);
        endcase
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge clock) begin
        logic [19:0] act;
        logic [19:0] x;
        if (sb.size() > 0) begin
            x   = sb.pop_front();
            act = {pc_wr, ir_wr, alu_src_a, reg_dst, mem_to_reg, reg_wr,
                   mem_r, mem_w, pc_src, alu_src_b, alu_op, halted, fault,
                   state};
            checks++;
            if (act !== x) begin
                errors++;
                $display("FAIL cyc%0d state got %0d want %0d outputs got %h want %h",
                         ncyc, act[3:0], x[3:0], act, x);
            end
            ncyc++;
        end
    end

    initial begin
        int r;
        int k;
        start     = 1'b0;
        op        = '0;
        eq        = 1'b0;
        mem_ready = 1'b0;

        rst_rec();
        instr(2, 0, 0, -1);
        instr(4, 0, 0, 0);
        instr(5, 0, 0, 0);
        instr(3, 0, TO, -1);
        instr(10, 0, 0, -1);
        instr(9, 0, 0, -1);
        instr(7, 0, 0, -1);
        instr(3, 0, TO - 1, -1);
        instr(2, TO - 1, 2, -1);
        instr(0, 0, 0, -1);
        instr(1, 1, 0, -1);
        instr(6, 0, 0, -1);
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 15);
            k = (r < 11) ? r : $urandom_range(0, 6);
            instr(k, -1, -1, -1);
        end

        while (plan.size() > 0) begin
            cyc_t c;
            c = plan.pop_front();
            @(posedge clock);
            #1;
            start     = !c.rst;
            op        = c.op;
            eq        = c.eq;
            mem_ready = c.mr;
            sb.push_back(c.exp);
        end
        repeat (3) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end, %0d entries pending", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
